// File: rtl/alu_sequencer_if.sv
// Command handshake bundle between a command source and alu_sequencer.
// Ports: cmd_valid/cmd_ready handshake, cmd_op/rd/rn/rm, cmd_imm.
interface alu_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [2:0]       cmd_rd;
  logic [2:0]       cmd_rn;
  logic [2:0]       cmd_rm;
  logic [WIDTH-1:0] cmd_imm;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_rd,
    output cmd_rn,
    output cmd_rm,
    output cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_rd,
    input  cmd_rn,
    input  cmd_rm,
    input  cmd_imm,
    output cmd_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle controller: fetches operands from an 8x16 register file,
// drives an external combinational ALU, captures result/Z, writes back.
// Ports: clk, reset (async high), cmd (slave handshake), alu_ain/bin/op,
// alu_out/alu_z from ALU, status_z/done/err, dbg_addr/dbg_data.
module alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             reset,
  alu_sequencer_if.slave   cmd,
  output logic [WIDTH-1:0] alu_ain,
  output logic [WIDTH-1:0] alu_bin,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  output logic             status_z,
  output logic             done,
  output logic             err,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [2:0] OP_MOVI = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_MVN  = 3'b100;
  localparam logic [2:0] OP_CMP  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDA,
    S_RDB,
    S_EXEC,
    S_WB,
    S_ERR
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rf [NREGS];
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [2:0]       op_q;
  logic [2:0]       rd_q;
  logic [2:0]       rn_q;
  logic [2:0]       rm_q;
  logic             ready_q;
  logic [1:0]       code;

  // ALU function code for the latched command; CMP is a subtract.
  always_comb begin
    code = 2'b00;
    unique case (1'b1)
      (op_q == OP_SUB),
      (op_q == OP_CMP): code = 2'b01;
      (op_q == OP_AND): code = 2'b10;
      (op_q == OP_MVN): code = 2'b11;
      default:          code = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      for (int i = 0; i < NREGS; i++)
        rf[i] <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      status_z <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      alu_op   <= 2'b00;
      ready_q  <= 1'b1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            op_q    <= cmd.cmd_op;
            rd_q    <= cmd.cmd_rd;
            rn_q    <= cmd.cmd_rn;
            rm_q    <= cmd.cmd_rm;
            ready_q <= 1'b0;
            unique case (1'b1)
              (cmd.cmd_op == OP_MOVI): begin
                c_q   <= cmd.cmd_imm;
                done  <= 1'b1;
                state <= S_WB;
              end
              (cmd.cmd_op == OP_ADD),
              (cmd.cmd_op == OP_SUB),
              (cmd.cmd_op == OP_AND),
              (cmd.cmd_op == OP_MVN),
              (cmd.cmd_op == OP_CMP): begin
                state <= S_RDA;
              end
              default: begin
                err   <= 1'b1;
                state <= S_ERR;
              end
            endcase
          end
        end
        S_RDA: begin
          a_q   <= rf[rn_q];
          state <= S_RDB;
        end
        S_RDB: begin
          b_q    <= rf[rm_q];
          alu_op <= code;
          state  <= S_EXEC;
        end
        S_EXEC: begin
          c_q      <= alu_out;
          status_z <= alu_z;
          alu_op   <= 2'b00;
          done     <= 1'b1;
          state    <= S_WB;
        end
        S_WB: begin
          if (op_q != OP_CMP)
            rf[rd_q] <= c_q;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        S_ERR: begin
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign alu_ain       = a_q;
  assign alu_bin       = b_q;
  assign dbg_data      = rf[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer.
// Models the external ALU and keeps an architectural register model.
module tb_alu_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] ain, bin, aout;
  logic [1:0]   aop;
  logic         az, sz, done, err;
  logic [2:0]   dbg_addr;
  logic [W-1:0] dbg_data;

  always #10 clk = ~clk;

  alu_sequencer_if #(.WIDTH(W)) ifc();

  alu_sequencer #(.WIDTH(W), .NREGS(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd      (ifc.slave),
    .alu_ain  (ain),
    .alu_bin  (bin),
    .alu_op   (aop),
    .alu_out  (aout),
    .alu_z    (az),
    .status_z (sz),
    .done     (done),
    .err      (err),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    aout = '0;
    case (aop)
      2'b00:   aout = ain + bin;
      2'b01:   aout = ain - bin;
      2'b10:   aout = ain & bin;
      default: aout = ~bin;
    endcase
  end
  assign az = (aout == '0);

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] m_r [8];
  logic         m_z;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_res(int op, logic [W-1:0] a,
                                           logic [W-1:0] b);
    case (op)
      1:       return a + b;
      2:       return a - b;
      3:       return a & b;
      4:       return ~b;
      default: return a - b;
    endcase
  endfunction

  function automatic int ref_code(int op);
    case (op)
      1:       return 0;
      3:       return 2;
      4:       return 3;
      default: return 1;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_z = 1'b0;
  endtask

  task automatic check_state(string tag);
    chk({tag, " ready"}, ifc.cmd_ready, 1);
    chk({tag, " z"}, sz, m_z);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk($sformatf("%s R%0d", tag, i), dbg_data, m_r[i]);
    end
  endtask

  task automatic peek(string tag, int idx, logic [W-1:0] exp);
    dbg_addr = 3'(idx);
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic issue(int op, int rd, int rn, int rm, logic [W-1:0] imm);
    int lat;
    int w;
    bit gd, ge;
    bit alu;
    logic [W-1:0] res;
    alu = (op >= 1 && op <= 5);
    w = 0;
    while (!ifc.cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready before cmd", ifc.cmd_ready, 1);
    ifc.cmd_op    = 3'(op);
    ifc.cmd_rd    = 3'(rd);
    ifc.cmd_rn    = 3'(rn);
    ifc.cmd_rm    = 3'(rm);
    ifc.cmd_imm   = imm;
    ifc.cmd_valid = 1'b1;
    lat = 0;
    gd  = 0;
    ge  = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) ifc.cmd_valid = 1'b0;
      if (alu && c == 3) begin
        chk("alu_op exec", aop, ref_code(op));
        chk("ain exec", ain, m_r[rn]);
        chk("bin exec", bin, m_r[rm]);
      end
      if (done || err) begin
        lat = c;
        gd  = done;
        ge  = err;
        break;
      end
    end
    chk($sformatf("latency op%0d", op), lat, (op <= 5) ? (alu ? 4 : 1) : 1);
    chk($sformatf("done op%0d", op), gd, op <= 5);
    chk($sformatf("err op%0d", op), ge, op > 5);
    if (op == 0) begin
      m_r[rd] = imm;
    end else if (alu) begin
      res = ref_res(op, m_r[rn], m_r[rm]);
      m_z = (res == '0);
      if (op != 5) m_r[rd] = res;
    end
    @(negedge clk);
    chk("done one pulse", done, 0);
    chk("err one pulse", err, 0);
    check_state($sformatf("after op%0d", op));
  endtask

  initial begin
    int dn [$];
    int cyc;
    bit any;
    reset         = 1'b1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = '0;
    ifc.cmd_rd    = '0;
    ifc.cmd_rn    = '0;
    ifc.cmd_rm    = '0;
    ifc.cmd_imm   = '0;
    dbg_addr      = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    issue(0, 0, 0, 0, 16'h1234);
    issue(0, 7, 0, 0, 16'hBEEF);
    issue(1, 3, 0, 7, '0);
    do_reset();
    chk("reset done", done, 0);
    chk("reset alu_op", aop, 0);
    check_state("reset");

    issue(0, 1, 0, 0, 16'h0005);
    issue(0, 2, 0, 0, 16'h0003);
    issue(1, 3, 1, 2, '0);
    peek("ADD R3", 3, 16'h0008);
    chk("ADD z", sz, 0);
    issue(2, 4, 1, 1, '0);
    peek("SUB R4", 4, 16'h0000);
    chk("SUB z", sz, 1);
    issue(0, 5, 0, 0, 16'hFFFF);
    issue(1, 6, 5, 2, '0);
    peek("ADD wrap R6", 6, 16'h0002);
    issue(4, 7, 0, 2, '0);
    peek("MVN R7", 7, 16'hFFFC);
    issue(5, 0, 1, 2, '0);
    chk("CMP z", sz, 0);
    issue(7, 0, 0, 0, '0);
    chk("illegal z held", sz, 0);
    issue(1, 1, 1, 1, '0);
    peek("double R1", 1, 16'h000A);

    for (int k = 0; k < 60; k++) begin
      issue($urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7),
            W'($urandom));
    end

    @(negedge clk);
    ifc.cmd_op    = 3'd5;
    ifc.cmd_rn    = 3'd1;
    ifc.cmd_rm    = 3'd2;
    ifc.cmd_rd    = 3'd0;
    ifc.cmd_valid = 1'b1;
    for (cyc = 1; cyc <= 22; cyc++) begin
      @(negedge clk);
      if (done) dn.push_back(cyc);
    end
    ifc.cmd_valid = 1'b0;
    chk("stream done count", dn.size(), 4);
    for (int k = 0; k + 1 < dn.size(); k++)
      chk($sformatf("stream gap %0d", k), dn[k+1] - dn[k], 5);
    repeat (6) @(negedge clk);
    m_z = (ref_res(5, m_r[1], m_r[2]) == '0);
    check_state("stream");

    ifc.cmd_op    = 3'd1;
    ifc.cmd_rd    = 3'd3;
    ifc.cmd_rn    = 3'd1;
    ifc.cmd_rm    = 3'd2;
    ifc.cmd_valid = 1'b1;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    any = 0;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    repeat (6) begin
      @(negedge clk);
      if (done || err) any = 1;
    end
    chk("abort no done", any, 0);
    check_state("abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
